// File: rtl/mul6_pkg.sv
// Shared widths, iteration count and FSM state type for the mul6_seq slow-path multiplier.
package mul6_pkg;
  localparam int DATA_W = 6;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ITER   = DATA_W;
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/adder6.sv
// 6-bit ripple-carry adder used for the partial-product accumulation.
module adder6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);
  logic [6:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 6; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[6];
  end
endmodule

// File: rtl/mul6_dp.sv
// Datapath for mul6_seq: operand magnitudes, shift-add accumulator and final sign correction.
module mul6_dp
  import mul6_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load,
  input  logic              clear,
  input  logic              step,
  input  logic              neg_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_op,
  output logic [PROD_W-1:0] prod
);
  logic [DATA_W-1:0] a_neg, b_neg, mag_a, mag_b;
  logic [DATA_W-1:0] mcand, sum;
  logic              cout, neg;
  logic [DATA_W:0]   partial;
  // p holds {acc_hi, acc_lo/mplier}; multiplier bits shift out as product bits shift in.
  logic [PROD_W-1:0] p;

  twocomp u_tc_a (.a(a), .y(a_neg));
  twocomp u_tc_b (.a(b), .y(b_neg));

  // -32 negates to itself, which read as unsigned is the correct magnitude 32.
  assign mag_a = (signed_op && a[DATA_W-1]) ? a_neg : a;
  assign mag_b = (signed_op && b[DATA_W-1]) ? b_neg : b;

  adder6 u_add (
    .a   (p[PROD_W-1:DATA_W]),
    .b   (mcand),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  assign partial = p[0] ? {cout, sum} : {1'b0, p[PROD_W-1:DATA_W]};

  // NOTE: every register here is small flop state, so all of it is reset; an abort must leave no stale product.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      p     <= '0;
      mcand <= '0;
      neg   <= 1'b0;
    end else if (clear) begin
      p     <= '0;
      mcand <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      p     <= {{DATA_W{1'b0}}, mag_b};
      mcand <= mag_a;
      neg   <= signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
    end else if (step) begin
      p <= {partial, p[DATA_W-1:1]};
    end else if (neg_en && neg) begin
      p <= ~p + PROD_W'(1);
    end
  end

  assign prod = p;
endmodule

// File: rtl/twocomp.sv
// 6-bit two's complement negation unit.
module twocomp (
  input  logic [5:0] a,
  output logic [5:0] y
);
  assign y = ~a + 6'd1;
endmodule

// File: rtl/mul6_seq.sv
// Multi-cycle 6x6 signed/unsigned shift-add multiplier with valid/ready on both sides.
// Optional: define MUL6_ZERO_BYPASS_EN to answer zero-operand requests directly from IDLE.
module mul6_seq
  import mul6_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              signed_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [PROD_W-1:0] prod_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);
  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load, clear, step, neg_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    clear     = 1'b0;
    step      = 1'b0;
    neg_en    = 1'b0;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          cnt_nxt = '0;
`ifdef MUL6_ZERO_BYPASS_EN
          if (a_i == '0 || b_i == '0) begin
            clear     = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = MUL;
          end
`else
          load      = 1'b1;
          state_nxt = MUL;
`endif
        end
      end
      MUL: begin
        step    = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER - 1)) state_nxt = SIGN;
      end
      SIGN: begin
        neg_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  mul6_dp u_dp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (load),
    .clear    (clear),
    .step     (step),
    .neg_en   (neg_en),
    .a        (a_i),
    .b        (b_i),
    .signed_op(signed_i),
    .prod     (prod_o)
  );
endmodule

// File: tb/tb_mul6_seq.sv
// Self-checking bench for mul6_seq: directed vectors with literal products plus randomized requests against an arithmetic model.
module tb_mul6_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [5:0]  a_i = '0;
  logic [5:0]  b_i = '0;
  logic        signed_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [11:0] prod_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_prod = '0;
  bit          mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  mul6_seq dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .signed_i(signed_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .prod_o  (prod_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer product, truncated to the 12-bit result field.
  function automatic logic [11:0] model(input logic [5:0] a, input logic [5:0] b, input logic s);
    int ia, ib, r;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    r  = ia * ib;
    return r[11:0];
  endfunction

  // While a result is presented it must equal the expected product and the block must be busy.
  always @(negedge clk_i) begin
    if (mon_en && valid_o === 1'b1) begin
      check("prod_o", {20'd0, prod_o}, {20'd0, exp_prod});
      check("ready_in_done", {31'd0, ready_o}, 32'd0);
      check("busy_in_done", {31'd0, busy_o}, 32'd1);
    end
  end

  // Called on a negedge with the block idle; returns on a negedge with the block idle again.
  task automatic run_req(input logic [5:0] a, input logic [5:0] b, input logic s,
                         input logic [11:0] exp, input int hold);
    int lat, n;
    lat = 8;
`ifdef MUL6_ZERO_BYPASS_EN
    if (a == 6'd0 || b == 6'd0) lat = 1;
`endif
    a_i = a; b_i = b; signed_i = s; valid_i = 1'b1; ready_i = 1'b0;
    exp_prod = exp;
    check("ready_idle", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i = 6'($urandom); b_i = 6'($urandom); signed_i = 1'($urandom);
    n = 1;
    while (valid_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("valid_seen", {31'd0, valid_o}, 32'd1);
    check("latency", n, lat);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1;
      a_i = 6'($urandom); b_i = 6'($urandom);
      @(negedge clk_i);
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_busy", {31'd0, busy_o}, 32'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("release_ready", {31'd0, ready_o}, 32'd1);
    check("release_valid", {31'd0, valid_o}, 32'd0);
    check("release_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ra, rb;
    logic       rs;

    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_prod", {20'd0, prod_o}, 32'd0);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_i);

    run_req(6'd5, 6'd3, 1'b1, 12'h00F, 0);
    run_req(6'h39, 6'd5, 1'b1, 12'hFDD, 0);
    run_req(6'h39, 6'd5, 1'b0, 12'h11D, 0);
    run_req(6'h20, 6'h20, 1'b1, 12'h400, 0);
    run_req(6'h3F, 6'h3F, 1'b0, 12'hF81, 0);
    run_req(6'h3F, 6'h01, 1'b1, 12'hFFF, 0);
    run_req(6'h20, 6'h1F, 1'b1, 12'hC20, 0);
    run_req(6'd7, 6'd9, 1'b0, 12'h03F, 5);

    // Abort in the middle of MUL: nothing may survive the reset.
    a_i = 6'd3; b_i = 6'd3; signed_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("mid_busy", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_prod", {20'd0, prod_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_req(6'd2, 6'd2, 1'b0, 12'h004, 0);

    run_req(6'd0, 6'h2F, 1'b1, 12'h000, 0);
    run_req(6'h2A, 6'd0, 1'b0, 12'h000, 1);

    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      rs = 1'($urandom);
      run_req(ra, rb, rs, model(ra, rb, rs), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
